// File: rtl/uart_cmd_rx_if.sv
// Command strobe and clock-digit bus between the UART command decoder and
// the lock/alarm top-level state machine.
interface uart_cmd_rx_if;
    logic       is_reset_cmd;
    logic       is_check_cmd;
    logic       is_start_cmd;
    logic       is_exit_cmd;
    logic       is_shutdown_cmd;
    logic       is_setcl_cmd;
    logic       wr_ry;
    logic [3:0] clock1;
    logic [3:0] clock2;
    logic [3:0] clock3;
    logic [3:0] clock4;
    logic [3:0] clock5;
    logic [3:0] clock6;
    logic       bad_cmd;
    logic       frame_err;

    modport master (
        output is_reset_cmd, is_check_cmd, is_start_cmd, is_exit_cmd,
               is_shutdown_cmd, is_setcl_cmd, wr_ry,
               clock1, clock2, clock3, clock4, clock5, clock6,
               bad_cmd, frame_err
    );

    modport slave (
        input  is_reset_cmd, is_check_cmd, is_start_cmd, is_exit_cmd,
               is_shutdown_cmd, is_setcl_cmd, wr_ry,
               clock1, clock2, clock3, clock4, clock5, clock6,
               bad_cmd, frame_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver, line assembler and fixed command decoder.
// MAX_LEN must be at least 12 so a full setcl line fits in the buffer.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_cmd_rx_if.master cmd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W        = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam logic [63:0] W_RESET    = 64'("reset");
    localparam logic [63:0] W_CHECK    = 64'("check");
    localparam logic [63:0] W_START    = 64'("start");
    localparam logic [63:0] W_EXIT     = 64'("exit");
    localparam logic [63:0] W_SHUTDOWN = 64'("shutdown");
    localparam logic [63:0] W_SETCL    = 64'("setcl ");

    // True when the first n characters of the line equal the n-char word w.
    function automatic logic prefix_eq(input logic [8*MAX_LEN-1:0] line,
                                       input logic [63:0] w, input int n);
        logic [63:0] wl;
        logic        eq;
        wl = w << (8 * (8 - n));
        eq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n && line[8*i +: 8] != wl[63-8*i -: 8]) eq = 1'b0;
        end
        return eq;
    endfunction

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_valid, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       rx_data;

    logic [7:0]         line_buf [MAX_LEN];
    logic [8*MAX_LEN-1:0] line_flat;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               match_q;
    logic               is_term_c, append_c;
    logic               hit_reset_c, hit_check_c, hit_start_c, hit_exit_c;
    logic               hit_shutdown_c, hit_setcl_c;

    logic       reset_q, check_q, start_q, exit_q, shutdown_q, setcl_q, wr_q, bad_q;
    logic [3:0] clk1_q, clk2_q, clk3_q, clk4_q, clk5_q, clk6_q;

    assign rx_data = shreg_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            byte_valid  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            byte_valid  <= byte_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Receiver next state: mid-bit sampling timed from the synchronised start edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_sync) byte_valid_d = 1'b1;
                    else         frame_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign is_term_c = (rx_data == CH_CR) || (rx_data == CH_LF);
    assign append_c  = !match_q && byte_valid && !is_term_c && (len_q < LEN_W'(MAX_LEN));

    // Line storage; stale characters beyond len_q are never looked at.
    always_ff @(posedge clk) begin
        if (append_c) line_buf[IDX_W'(len_q)] <= rx_data;
    end

    // Flattened view of the buffer for the matcher.
    always_comb begin
        for (int i = 0; i < int'(MAX_LEN); i++) line_flat[8*i +: 8] = line_buf[i];
    end

    // Command matcher, evaluated in the cycle after the terminator.
    always_comb begin
        hit_reset_c    = (len_q == LEN_W'(5)) && prefix_eq(line_flat, W_RESET, 5);
        hit_check_c    = (len_q == LEN_W'(5)) && prefix_eq(line_flat, W_CHECK, 5);
        hit_start_c    = (len_q == LEN_W'(5)) && prefix_eq(line_flat, W_START, 5);
        hit_exit_c     = (len_q == LEN_W'(4)) && prefix_eq(line_flat, W_EXIT, 4);
        hit_shutdown_c = (len_q == LEN_W'(8)) && prefix_eq(line_flat, W_SHUTDOWN, 8);
        hit_setcl_c    = (len_q == LEN_W'(12)) && prefix_eq(line_flat, W_SETCL, 6);
        for (int i = 6; i < 12; i++) begin
            if (line_flat[8*i +: 8] < CH_0 || line_flat[8*i +: 8] > CH_9) hit_setcl_c = 1'b0;
        end
    end

    // Line assembly, overflow tracking and registered decode outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            ovf_q      <= 1'b0;
            match_q    <= 1'b0;
            reset_q    <= 1'b0;
            check_q    <= 1'b0;
            start_q    <= 1'b0;
            exit_q     <= 1'b0;
            shutdown_q <= 1'b0;
            setcl_q    <= 1'b0;
            wr_q       <= 1'b0;
            bad_q      <= 1'b0;
            clk1_q     <= '0;
            clk2_q     <= '0;
            clk3_q     <= '0;
            clk4_q     <= '0;
            clk5_q     <= '0;
            clk6_q     <= '0;
        end else begin
            match_q    <= 1'b0;
            reset_q    <= 1'b0;
            check_q    <= 1'b0;
            start_q    <= 1'b0;
            exit_q     <= 1'b0;
            shutdown_q <= 1'b0;
            setcl_q    <= 1'b0;
            wr_q       <= 1'b0;
            bad_q      <= 1'b0;
            if (match_q) begin
                len_q <= '0;
                ovf_q <= 1'b0;
                if (ovf_q)               bad_q      <= 1'b1;
                else if (hit_reset_c)    reset_q    <= 1'b1;
                else if (hit_check_c)    check_q    <= 1'b1;
                else if (hit_start_c)    start_q    <= 1'b1;
                else if (hit_exit_c)     exit_q     <= 1'b1;
                else if (hit_shutdown_c) shutdown_q <= 1'b1;
                else if (hit_setcl_c) begin
                    setcl_q <= 1'b1;
                    wr_q    <= 1'b1;
                    clk1_q  <= 4'(line_flat[8*6  +: 8] - CH_0);
                    clk2_q  <= 4'(line_flat[8*7  +: 8] - CH_0);
                    clk3_q  <= 4'(line_flat[8*8  +: 8] - CH_0);
                    clk4_q  <= 4'(line_flat[8*9  +: 8] - CH_0);
                    clk5_q  <= 4'(line_flat[8*10 +: 8] - CH_0);
                    clk6_q  <= 4'(line_flat[8*11 +: 8] - CH_0);
                end else begin
                    bad_q <= 1'b1;
                end
            end else if (byte_valid) begin
                if (is_term_c) begin
                    if (ovf_q || len_q != '0) match_q <= 1'b1;
                end else if (len_q < LEN_W'(MAX_LEN)) begin
                    len_q <= len_q + LEN_W'(1);
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign cmd.is_reset_cmd    = reset_q;
    assign cmd.is_check_cmd    = check_q;
    assign cmd.is_start_cmd    = start_q;
    assign cmd.is_exit_cmd     = exit_q;
    assign cmd.is_shutdown_cmd = shutdown_q;
    assign cmd.is_setcl_cmd    = setcl_q;
    assign cmd.wr_ry           = wr_q;
    assign cmd.bad_cmd         = bad_q;
    assign cmd.frame_err       = frame_err_q;
    assign cmd.clock1          = clk1_q;
    assign cmd.clock2          = clk2_q;
    assign cmd.clock3          = clk3_q;
    assign cmd.clock4          = clk4_q;
    assign cmd.clock5          = clk5_q;
    assign cmd.clock6          = clk6_q;

endmodule
